// File: rtl/cla_operand_sequencer.sv
// ---------------------------------------------------------------------------
// cla_operand_sequencer
//
// Sequential front/back stage wrapped around an external combinational
// carry-lookahead adder. A single byte-wide valid/ready stream delivers
// operand A, then operand B together with its carry-in selection. The two
// operands and the carry-in are held on registered outputs so the adder sees
// stable inputs for one full settle cycle. The adder's sum and carry-out are
// then captured into a result register and offered downstream through a
// valid/ready handshake. The chain option feeds the previous carry-out back
// in as carry-in, so multi-byte additions run as successive operand pairs.
//
// Ports
//   clk        in   1      clock, all state updates on the rising edge
//   rst        in   1      synchronous active-high reset
//   in_data    in   WIDTH  operand byte (A first, then B)
//   in_cin     in   1      carry-in, sampled together with the B byte
//   in_chain   in   1      sampled with B; 1 = use stored carry-out as carry-in
//   in_valid   in   1      in_data is valid
//   in_ready   out  1      block accepts in_data this cycle
//   op_a       out  WIDTH  registered operand A to the adder
//   op_b       out  WIDTH  registered operand B to the adder
//   op_cin     out  1      registered carry-in to the adder
//   sum_in     in   WIDTH  adder sum (combinational from op_*)
//   cout_in    in   1      adder carry-out
//   res_sum    out  WIDTH  registered result sum
//   res_cout   out  1      registered result carry-out
//   res_valid  out  1      result available
//   res_ready  in   1      downstream accepts the result
//   busy       out  1      high in every state except WAIT_A
// ---------------------------------------------------------------------------
module cla_operand_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_cin,
  input  logic             in_chain,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             op_cin,
  input  logic [WIDTH-1:0] sum_in,
  input  logic             cout_in,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy
);

  // Transaction phases: collect A, collect B, let the adder settle and
  // capture, then present the result until downstream takes it.
  typedef enum logic [1:0] {
    WAIT_A = 2'd0,
    WAIT_B = 2'd1,
    ADD    = 2'd2,
    OUT    = 2'd3
  } state_e;

  state_e           state_q,     state_d;
  logic [WIDTH-1:0] op_a_q,      op_a_d;
  logic [WIDTH-1:0] op_b_q,      op_b_d;
  logic             op_cin_q,    op_cin_d;
  logic [WIDTH-1:0] res_sum_q,   res_sum_d;
  logic             res_cout_q,  res_cout_d;
  logic             res_valid_q, res_valid_d;
  logic             last_cout_q, last_cout_d;

  logic in_fire;
  logic res_fire;

  // Handshakes only count when both sides agree in the same cycle. in_ready
  // and res_valid are already gated by state, so valid bytes arriving while
  // the block is busy are simply dropped rather than queued.
  assign in_fire  = in_valid  & in_ready;
  assign res_fire = res_valid_q & res_ready;

  // Next-state and datapath-load logic. Every register defaults to holding
  // its value; only the accepting handshake of each phase moves data, which
  // keeps op_* stable across the whole ADD cycle for the external adder.
  always_comb begin
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_cin_d    = op_cin_q;
    res_sum_d   = res_sum_q;
    res_cout_d  = res_cout_q;
    res_valid_d = res_valid_q;
    last_cout_d = last_cout_q;
    in_ready    = 1'b0;

    case (state_q)
      WAIT_A: begin
        in_ready = 1'b1;
        if (in_fire) begin
          op_a_d  = in_data;
          state_d = WAIT_B;
        end
      end

      WAIT_B: begin
        in_ready = 1'b1;
        // The chain flag selects the carry left over from the previous pair,
        // letting a wide addition proceed one byte pair at a time.
        if (in_fire) begin
          op_b_d   = in_data;
          op_cin_d = in_chain ? last_cout_q : in_cin;
          state_d  = ADD;
        end
      end

      ADD: begin
        // The adder has had the full cycle since B was loaded to settle.
        res_sum_d   = sum_in;
        res_cout_d  = cout_in;
        last_cout_d = cout_in;
        res_valid_d = 1'b1;
        state_d     = OUT;
      end

      OUT: begin
        // Result is frozen here until downstream accepts it. in_ready stays
        // low during the handshake cycle itself, so no A byte slips in.
        if (res_fire) begin
          res_valid_d = 1'b0;
          state_d     = WAIT_A;
        end
      end

      default: begin
        state_d = WAIT_A;
      end
    endcase
  end

  // State and datapath registers. Reset wins over any handshake in the same
  // cycle and discards a partially loaded operand pair, including the
  // remembered carry so a fresh chain starts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WAIT_A;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_cin_q    <= 1'b0;
      res_sum_q   <= '0;
      res_cout_q  <= 1'b0;
      res_valid_q <= 1'b0;
      last_cout_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_cin_q    <= op_cin_d;
      res_sum_q   <= res_sum_d;
      res_cout_q  <= res_cout_d;
      res_valid_q <= res_valid_d;
      last_cout_q <= last_cout_d;
    end
  end

  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign op_cin    = op_cin_q;
  assign res_sum   = res_sum_q;
  assign res_cout  = res_cout_q;
  assign res_valid = res_valid_q;
  assign busy      = (state_q != WAIT_A);

endmodule

// File: doc/cla_operand_sequencer.md
# cla_operand_sequencer

Sequential front/back stage for the 8-bit carry-lookahead adder. It collects operand A, then operand B plus carry-in, from a single byte-wide valid/ready stream and holds them on registered outputs that drive the combinational adder. It captures the adder's sum and carry-out into a result register, which a valid/ready handshake presents downstream. A chain option uses the previous carry-out as carry-in, so multi-byte additions run as successive operand pairs.

## Interface
- WIDTH, 8: operand/sum width; must match the adder width.
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_data  in  WIDTH  operand byte (A first, then B)
- in_cin  in  1  carry-in, sampled with the B byte only
- in_chain  in  1  sampled with the B byte; 1 = use stored last_cout as carry-in, ignore in_cin
- in_valid  in  1  in_data is valid
- in_ready  out  1  block accepts in_data this cycle
- op_a  out  WIDTH  registered operand A to adder
- op_b  out  WIDTH  registered operand B to adder
- op_cin  out  1  registered carry-in to adder
- sum_in  in  WIDTH  adder sum (combinational from op_*)
- cout_in  in  1  adder carry-out
- res_sum  out  WIDTH  registered result sum
- res_cout  out  1  registered result carry-out
- res_valid  out  1  result available
- res_ready  in  1  downstream accepts result
- busy  out  1  high in any state other than WAIT_A

## Operation
- One clock and one reset: clk, with synchronous active-high rst.
- FSM states: WAIT_A, WAIT_B, ADD, OUT.
- WAIT_A: in_ready=1. On in_valid: op_a<=in_data, go to WAIT_B. Otherwise stay.
- WAIT_B: in_ready=1. On in_valid: op_b<=in_data, op_cin<=(in_chain ? last_cout : in_cin), go to ADD. Otherwise stay indefinitely; op_a is held.
- ADD: in_ready=0. Capture res_sum<=sum_in, res_cout<=cout_in, last_cout<=cout_in, res_valid<=1. Go to OUT.
- OUT: in_ready=0, res_valid=1. res_sum and res_cout stay stable until the handshake completes. On res_ready: res_valid<=0, go to WAIT_A.
- A handshake occurs only when valid and ready are both high in the same cycle. in_valid while in_ready=0 is ignored; nothing is captured or queued.
- res_ready while res_valid=0 is ignored.
- Arithmetic: {res_cout,res_sum} = op_a + op_b + op_cin, a full WIDTH+1-bit result. Wrap-around is reported through res_cout and never saturates.
- last_cout is an internal register, reset to 0. It is updated only in ADD.
- op_a, op_b and op_cin change only on their accepting handshakes. They are never cleared between transactions, except by rst.
- Reset, asserted in any state including mid-transaction: the next edge forces WAIT_A. That edge clears op_a, op_b, op_cin, res_sum, res_cout, res_valid and last_cout to 0. Any partially loaded pair is discarded.
- rst has priority over every handshake in the same cycle.

## Timing
- Reset values: in_ready=1, busy=0, res_valid=0, and all data outputs 0.
- A accepted at edge t. B is accepted at edge t+1 at the earliest.
- ADD occupies cycle t+1..t+2. res_valid rises after edge t+2, one cycle after B is accepted.
- The adder gets one full cycle to settle: op_* are stable during ADD.
- Minimum cycle is four edges per result (WAIT_A, WAIT_B, ADD, OUT with res_ready=1).
- OUT→WAIT_A takes one edge. in_ready is 0 during the handshake cycle, so no A byte is accepted in that cycle.
- busy is combinational from state. in_ready is combinational from state and does not depend on in_valid.

## Test plan
- Reset: hold rst 2 cycles with in_valid=1, in_data=0xAA → in_ready=1, busy=0, res_valid=0, op_a=op_b=res_sum=0x00, and no capture.
- Basic add: A=0x3C, B=0x42, in_cin=0, res_ready=1 → res_valid rises one cycle after B is accepted, with res_sum=0x7E, res_cout=0.
- Carry and chain: A=0xFF, B=0x01, cin=0 → 0x00/cout=1. Next pair A=0x00, B=0x00, in_chain=1, in_cin=0 → op_cin=1, result 0x01/cout=0.
- Backpressure: after result A=0x80, B=0x80, cin=1, hold res_ready=0 for 5 cycles while pulsing in_valid → res_sum=0x01, res_cout=1 held stable, and in_ready=0. No operand is captured. res_ready=1 → back to WAIT_A.
- Input gaps: in_valid low 3 cycles between A=0x10 and B=0x05 → FSM stays in WAIT_B with op_a=0x10 held; result 0x15/cout=0.
- Reset mid-transaction: A=0xF0 accepted, then rst for 1 cycle → state WAIT_A, op_a=0x00, last_cout=0. Then A=0x01, B=0x01, in_chain=1 → result 0x02/cout=0.
